// File: rtl/uart_pkg.sv
// uart_pkg: framing constants and receiver state type shared by the UART transmitter and receiver.
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int DEF_CLKS_PER_BIT = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: valid/ready byte port from the receiver (master) to the core (slave).
interface uart_rx_if;
    import uart_pkg::*;
    logic [DATA_BITS-1:0] r_data_port;
    logic                 r_data_port_vld;
    logic                 r_data_port_rdy;

    modport master (output r_data_port, r_data_port_vld, input r_data_port_rdy);
    modport slave (input r_data_port, r_data_port_vld, output r_data_port_rdy);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer resetting to the idle-high line level so reset never fakes a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic m;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, m} <= 2'b11;
        else        {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 deserializer with mid-bit sampling, a one-entry output buffer and framing/overrun reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rxd_port,
    uart_rx_if.master    rx,
    output logic         busy_port,
    output logic         frame_err_port,
    output logic         overrun_port
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    uart_rx_state_e       state;
    logic                 rxd_s;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] sh;

    uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .d(rxd_port), .q(rxd_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            bit_idx            <= '0;
            sh                 <= '0;
            rx.r_data_port     <= '0;
            rx.r_data_port_vld <= 1'b0;
            busy_port          <= 1'b0;
            frame_err_port     <= 1'b0;
            overrun_port       <= 1'b0;
        end else begin
            frame_err_port <= 1'b0;
            overrun_port   <= 1'b0;
            if (rx.r_data_port_vld && rx.r_data_port_rdy) rx.r_data_port_vld <= 1'b0;
            case (state)
                IDLE:
                    if (!rxd_s) begin
                        state     <= START;
                        cnt       <= HALF;
                        busy_port <= 1'b1;
                    end
                START:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (!rxd_s) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        cnt     <= FULL;
                    end else begin
                        state     <= IDLE;
                        busy_port <= 1'b0;
                    end
                DATA:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        sh[bit_idx] <= rxd_s;
                        cnt         <= FULL;
                        if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end
                STOP:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (rxd_s) begin
                        state     <= IDLE;
                        busy_port <= 1'b0;
                        // a byte accepted this very cycle frees the buffer for the new one
                        if (!rx.r_data_port_vld || rx.r_data_port_rdy) begin
                            rx.r_data_port     <= sh;
                            rx.r_data_port_vld <= 1'b1;
                        end else overrun_port <= 1'b1;
                    end else begin
                        state          <= WAIT_IDLE;
                        frame_err_port <= 1'b1;
                    end
                WAIT_IDLE:
                    if (rxd_s) begin
                        state     <= IDLE;
                        busy_port <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames checked against a byte-level model of the receive buffer.
module tb_uart_rx;
    localparam int CPB = 8;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
    logic busy, fe, ov;
    uart_rx_if rx ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rxd_port(rxd), .rx(rx),
        .busy_port(busy), .frame_err_port(fe), .overrun_port(ov)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    int checks = 0, errors = 0;
    int t0 = 0, fe_cnt, ov_cnt, vld_hi, viol;
    int rise_q[$];
    logic [7:0] got_q[$];
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;

    // observe between edges: what the next rising edge will see
    always @(negedge clk) begin
        if (rst_n) begin
            fe_cnt += int'(fe);
            ov_cnt += int'(ov);
            if (rx.r_data_port_vld) vld_hi++;
            if (rx.r_data_port_vld && !pv) rise_q.push_back(edge_n - t0);
            if (rx.r_data_port_vld && rx.r_data_port_rdy) got_q.push_back(rx.r_data_port);
            if (pv && !pr && (!rx.r_data_port_vld || rx.r_data_port !== pd)) viol++;
        end
        pv = rst_n && rx.r_data_port_vld;
        pr = rx.r_data_port_rdy;
        pd = rx.r_data_port;
    end

    logic       m_vld;
    logic [7:0] m_data;
    int         m_ov;
    logic [7:0] m_q[$];

    task automatic model_clear();
        m_vld = 1'b0; m_data = '0; m_ov = 0; m_q.delete();
        fe_cnt = 0; ov_cnt = 0; vld_hi = 0; viol = 0; rise_q.delete(); got_q.delete();
    endtask

    task automatic model_frame(input logic [7:0] b, input logic rdy_at);
        if (m_vld && !rdy_at) m_ov++;
        else begin
            if (m_vld) m_q.push_back(m_data);
            m_vld = 1'b1; m_data = b;
        end
    endtask

    task automatic model_drain();
        if (m_vld) m_q.push_back(m_data);
        m_vld = 1'b0;
    endtask

    function automatic int q_diff();
        int d;
        d = int'(got_q.size() != m_q.size());
        for (int i = 0; i < got_q.size() && i < m_q.size(); i++) if (got_q[i] !== m_q[i]) d++;
        return d;
    endfunction

    function automatic int bad_rises(input int n);
        int d;
        d = int'(rise_q.size() != n);
        foreach (rise_q[i]) if (rise_q[i] != LAT) d++;
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        t0 = edge_n;
        rxd = 1'b0;
        repeat (CPB) step();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) step();
        end
        rxd = stop;
        repeat (CPB) step();
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rxd = 1'b1; rx.r_data_port_rdy = 1'b1;
        repeat (3) step();
        checks++;
        if ({busy, fe, ov, rx.r_data_port_vld, rx.r_data_port} !== 12'h0) begin
            errors++; $display("FAIL reset_outputs: got %h want 000", {busy, fe, ov, rx.r_data_port_vld, rx.r_data_port});
        end
        rst_n = 1'b1;
        repeat (3) step();
        rxd = 1'b0;
        repeat (30) step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_frame: got %b want 1", busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rx.r_data_port_vld} !== 2'b00) begin
            errors++; $display("FAIL async_reset: got %b want 00", {busy, rx.r_data_port_vld});
        end
        rxd = 1'b1;
        step(); step();
        rst_n = 1'b1;
        repeat (5) step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b want 0", busy); end
        model_clear();
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1); model_drain();
        repeat (5) step();
        checks++;
        if (q_diff() != 0) begin errors++; $display("FAIL reset_next_frame: got %0d bytes first %h want 5a", got_q.size(), got_q.size() ? got_q[0] : 8'h0); end
        checks++;
        if (fe_cnt + ov_cnt != 0) begin errors++; $display("FAIL reset_errors: got fe %0d ov %0d want 0", fe_cnt, ov_cnt); end
    endtask

    task automatic test_single();
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            model_clear();
            send_frame(b, 1'b1);
            model_frame(b, 1'b1); model_drain();
            repeat (5) step();
            checks++;
            if (q_diff() != 0) begin errors++; $display("FAIL single_data: got %h want %h", got_q.size() ? got_q[0] : 8'h0, b); end
            checks++;
            if (bad_rises(1) != 0) begin errors++; $display("FAIL single_latency: got %0d want %0d", rise_q.size() ? rise_q[0] : -1, LAT); end
            checks++;
            if (vld_hi != 1) begin errors++; $display("FAIL single_vld_len: got %0d want 1", vld_hi); end
            checks++;
            if ({fe_cnt, ov_cnt, 31'(busy)} != 0) begin errors++; $display("FAIL single_flags: got fe %0d ov %0d busy %b want 0", fe_cnt, ov_cnt, busy); end
        end
    endtask

    task automatic test_glitch();
        model_clear();
        rxd = 1'b0;
        repeat (2) step();
        rxd = 1'b1;
        repeat (20) step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
        checks++;
        if (vld_hi + fe_cnt + ov_cnt != 0) begin
            errors++; $display("FAIL glitch_outputs: got vld %0d fe %0d ov %0d want 0", vld_hi, fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_framing();
        model_clear();
        send_frame(8'h3C, 1'b0);
        rxd = 1'b0;
        repeat (40) step();
        rxd = 1'b1;
        repeat (10) step();
        checks++;
        if (fe_cnt != 1) begin errors++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt); end
        checks++;
        if (vld_hi + ov_cnt != 0) begin errors++; $display("FAIL frame_err_no_vld: got vld %0d ov %0d want 0", vld_hi, ov_cnt); end
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1); model_drain();
        repeat (5) step();
        checks++;
        if (q_diff() != 0) begin errors++; $display("FAIL frame_err_recover: got %h want 11", got_q.size() ? got_q[0] : 8'h0); end
    endtask

    task automatic test_overrun();
        model_clear();
        rx.r_data_port_rdy = 1'b0;
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        model_frame(8'h01, 1'b0); model_frame(8'h02, 1'b0);
        repeat (5) step();
        checks++;
        if ({rx.r_data_port_vld, rx.r_data_port} !== {m_vld, m_data}) begin
            errors++; $display("FAIL overrun_hold: got %b/%h want %b/%h", rx.r_data_port_vld, rx.r_data_port, m_vld, m_data);
        end
        checks++;
        if (ov_cnt != m_ov) begin errors++; $display("FAIL overrun_pulses: got %0d want %0d", ov_cnt, m_ov); end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL overrun_stable: got %0d changes want 0", viol); end
        rx.r_data_port_rdy = 1'b1;
        repeat (3) step();
        model_drain();
        checks++;
        if (q_diff() != 0) begin errors++; $display("FAIL overrun_drain: got %0d bytes want %0d", got_q.size(), m_q.size()); end
        rx.r_data_port_rdy = 1'b0;
        model_clear();
        send_frame(8'h01, 1'b1);
        fork
            send_frame(8'h02, 1'b1);
            begin
                repeat (LAT - 1) step();
                rx.r_data_port_rdy = 1'b1;
                step();
                rx.r_data_port_rdy = 1'b0;
            end
        join
        model_frame(8'h01, 1'b0); model_frame(8'h02, 1'b1);
        repeat (5) step();
        checks++;
        if ({rx.r_data_port_vld, rx.r_data_port} !== {m_vld, m_data}) begin
            errors++; $display("FAIL accept_in_delivery: got %b/%h want %b/%h", rx.r_data_port_vld, rx.r_data_port, m_vld, m_data);
        end
        checks++;
        if (ov_cnt != m_ov || q_diff() != 0) begin
            errors++; $display("FAIL accept_no_overrun: got ov %0d bytes %0d want ov %0d bytes %0d", ov_cnt, got_q.size(), m_ov, m_q.size());
        end
        rx.r_data_port_rdy = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        model_clear();
        rx.r_data_port_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        model_drain();
        repeat (5) step();
        checks++;
        if (q_diff() != 0) begin errors++; $display("FAIL b2b_data: got %0d bytes want %0d", got_q.size(), m_q.size()); end
        checks++;
        if (bad_rises(5) != 0 || vld_hi != 5) begin
            errors++; $display("FAIL b2b_timing: got %0d rises %0d vld cycles want 5 rises at %0d", rise_q.size(), vld_hi, LAT);
        end
        checks++;
        if (fe_cnt + ov_cnt != 0) begin errors++; $display("FAIL b2b_errors: got fe %0d ov %0d want 0", fe_cnt, ov_cnt); end
    endtask

    initial begin
        rx.r_data_port_rdy = 1'b0;
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
